pkt_inbuf: RTL
==============

# pkt_inbuf

Parametrised switch input-port buffer. Parses the 2-bit-flagged flit stream on one switch input, generates the buffer write enable, and stores admitted packets in a DEPTH-entry FIFO. Exposes a one-hot output-port request per queued packet and replays granted packets toward the crossbar. Sits between a switch input pin and the switch arbiter/crossbar; one instance per input port.

## Interface

Parameters:

- DATAW, 8: flit payload width.
- NPORT, 4: number of switch output ports.
- DEPTH, 8: FIFO entries (flits), power of two.
- MAXLEN, 4: maximum stored flits per packet, at most DEPTH.

Ports (DSTW = $clog2(NPORT), CW = $clog2(DEPTH)+1):

- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pkti  in  DATAW+2  input flit. Bits [DATAW+1:DATAW] are the flag: 00 idle, 10 head, 01 body, 11 tail. Head payload bits [DSTW-1:0] are the destination port.
- we  out  1  combinational FIFO write enable for the current pkti.
- req  out  NPORT  registered one-hot request for the destination of the front packet.
- grant  in  NPORT  arbiter grant. Only grant[dst] is used.
- pkto  out  DATAW+2  registered output flit. 00 when idle.
- cnt  out  CW  registered FIFO occupancy.
- drop_cnt  out  8  saturating drop/truncate event counter. See Configuration.

## Operation

Input FSM, states I_IDLE, I_RECV, I_DROP:

- **I_IDLE**
  - Head with cnt ≤ DEPTH−MAXLEN: the head is written, flit counter = 1, go to I_RECV.
  - Head with insufficient space: the head is not written, drop event, go to I_DROP.
  - Body, tail or idle: ignored, we=0. This covers orphan flits.
- **I_RECV**
  - Body: written and the flit counter increments.
  - Tail: written, go to I_IDLE.
  - Idle flag: ignored, stay in I_RECV.
  - Head: treated as an implicit tail. The last stored flit is not rewritten. The new head is evaluated as in I_IDLE in the same cycle.
  - Truncation: when the flit counter reaches MAXLEN on a non-tail flit, that flit is stored with flag forced to 11, a drop event is raised, and the FSM goes to I_DROP.
- **I_DROP**
  - All flits discard until a tail is seen, then go to I_IDLE.
  - A head in this state restarts evaluation as in I_IDLE.

Write enable:

- we = 1 exactly when a flit is written.
- Admission uses the registered cnt and ignores any same-cycle pop. Because admission reserves MAXLEN entries, the FIFO never overflows.

Output FSM, states O_IDLE, O_REQ, O_SEND:

- **O_IDLE**: when the FIFO front is a head flit, register req = 1<<dst and go to O_REQ.
- **O_REQ**: hold req until grant[dst]=1. On that edge pop the head to pkto and go to O_SEND.
- **O_SEND**
  - While grant[dst]=1 and the FIFO is non-empty: pop one flit per cycle into pkto.
  - If grant drops or the FIFO is empty: pkto=00 and the position is held; no flit is lost or repeated.
  - After the tail is popped: req=0 and go to O_IDLE.
  - req stays asserted throughout O_SEND.

Counters:

- cnt = writes − pops, updated every edge. A simultaneous push and pop leaves it unchanged.
- Pointers wrap modulo DEPTH.

## Timing

Reset values (asynchronous on rst_n low):

- req=0, pkto=0, cnt=0, drop_cnt=0.
- Both FSMs go to their idle states and the pointers go to 0.
- A partial packet present at reset is lost.
- we is combinational and is forced 0 while rst_n is low.

Latency:

- A head sampled at edge N gives req valid after edge N+1.
- With grant[dst] high, pkto carries the head after edge N+2, then one flit per edge.
- Minimum gap between consecutive packets at the output: 1 cycle in O_IDLE. req drops for at least one cycle between packets.

## Configuration

PKT_INBUF_STATS_EN:

- Defined: drop_cnt increments by 1 on each admission drop and each truncation, saturating at 255.
- Undefined: the counter logic is omitted and drop_cnt is tied to 0.
- All other behaviour is identical in both builds.

## Test plan

All scenarios use DATAW=8, NPORT=4, DEPTH=8, MAXLEN=4, PKT_INBUF_STATS_EN defined.

1. **Basic forward.** Stimulus: 10_1001_0001, 01_1001_0000, 01_1001_0001, 11_1001_0010 on consecutive edges, grant=4'b0010 constant. Required: req=4'b0010 one cycle after the head; pkto replays the four flits back-to-back starting two cycles after the head; req=0 after the tail; cnt returns to 0.
2. **Admission drop.** Stimulus: grant=0; two 4-flit packets to port 0 (cnt=8), then a third 4-flit packet. Required: we=0 for all third-packet flits, cnt stays 8, drop_cnt=1.
3. **Truncation.** Stimulus: a 6-flit packet (head, 4 body, tail) to port 2, grant=4'b0100. Required: 4 flits stored, and pkto's 4th flit has flag 11; flits 5–6 are discarded; drop_cnt=1.
4. **Grant withdrawal.** Stimulus: grant[1] deasserted for 3 cycles after the 2nd flit of scenario 1. Required: pkto=00 for those 3 cycles; the remaining 2 flits follow in order with none duplicated.
5. **Orphans and reset.** Stimulus: body 01_0000_0001 with no preceding head, then rst_n pulsed low mid-packet. Required: the orphan is not written (we=0); after reset all outputs are 0, and a fresh packet behaves exactly as in scenario 1.

Source files
------------

// File: rtl/pkt_inbuf.sv
// pkt_inbuf - switch input-port buffer.
//
// Parses the flagged flit stream arriving on one switch input, decides which
// flits are admitted, stores them in a DEPTH-entry FIFO and replays each queued
// packet toward the crossbar once the arbiter grants its destination port.
//
// Flit flag (bits [DATAW+1:DATAW]): 00 idle, 10 head, 01 body, 11 tail.
// Head payload bits [DSTW-1:0] carry the destination output port.
//
// Ports:
//   clk       clock, rising edge
//   rst_n     asynchronous active-low reset
//   pkti      input flit
//   we        combinational FIFO write enable for the current pkti
//   req       registered one-hot request for the front packet's destination
//   grant     arbiter grant, only grant[dst] is looked at
//   pkto      registered output flit, 0 when nothing is sent
//   cnt       registered FIFO occupancy
//   drop_cnt  saturating count of admission drops and truncations
//
// Build option: define PKT_INBUF_STATS_EN to include the drop_cnt counter;
// without it drop_cnt is tied to 0.
//
// Input FSM
//   state  | meaning
//   I_IDLE | between packets, waiting for a head
//   I_RECV | storing the flits of an admitted packet
//   I_DROP | discarding the rest of a rejected/truncated packet
// Output FSM
//   state  | meaning
//   O_IDLE | no packet in flight, looking for a head at the FIFO front
//   O_REQ  | requesting the front packet's port, waiting for the grant
//   O_SEND | replaying the packet, one flit per granted cycle
module pkt_inbuf #(
    parameter int DATAW  = 8,
    parameter int NPORT  = 4,
    parameter int DEPTH  = 8,
    parameter int MAXLEN = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [DATAW+1:0]          pkti,
    output logic                      we,
    output logic [NPORT-1:0]          req,
    input  logic [NPORT-1:0]          grant,
    output logic [DATAW+1:0]          pkto,
    output logic [$clog2(DEPTH):0]    cnt,
    output logic [7:0]                drop_cnt
);

    localparam int FW   = DATAW + 2;
    localparam int DSTW = (NPORT > 1) ? $clog2(NPORT) : 1;
    localparam int PW   = $clog2(DEPTH);
    localparam int CW   = PW + 1;
    localparam int FCW  = $clog2(MAXLEN + 1);

    localparam logic [1:0] F_HEAD = 2'b10;
    localparam logic [1:0] F_BODY = 2'b01;
    localparam logic [1:0] F_TAIL = 2'b11;

    typedef enum logic [1:0] {I_IDLE, I_RECV, I_DROP} in_state_t;
    typedef enum logic [1:0] {O_IDLE, O_REQ, O_SEND} out_state_t;

    in_state_t        in_st, in_nxt;
    out_state_t       o_st;
    logic [FCW-1:0]   fcnt, fcnt_nxt;
    logic             we_int;
    logic             drop_ev;
    logic [FW-1:0]    wdata;
    logic [1:0]       in_flag;
    logic             space_ok;

    logic [FW-1:0]    mem [DEPTH];
    logic [PW-1:0]    wptr, rptr;
    logic [FW-1:0]    front;
    logic [1:0]       front_flag;
    logic             empty;
    logic             pop;
    logic [DSTW-1:0]  dst;

    assign in_flag  = pkti[FW-1:DATAW];
    // Admission reserves room for a full-length packet, so the FIFO cannot
    // overflow even though pops in the same cycle are not credited.
    assign space_ok = (cnt <= CW'(DEPTH - MAXLEN));

    // ---------------- input side ----------------
    always_comb begin
        we_int   = 1'b0;
        wdata    = pkti;
        in_nxt   = in_st;
        fcnt_nxt = fcnt;
        drop_ev  = 1'b0;
        // A head is evaluated identically in every state; in I_RECV it also
        // closes the current packet without rewriting its last flit.
        if (in_flag == F_HEAD) begin
            if (space_ok) begin
                we_int   = 1'b1;
                fcnt_nxt = FCW'(1);
                in_nxt   = I_RECV;
            end else begin
                drop_ev = 1'b1;
                in_nxt  = I_DROP;
            end
        end else begin
            case (in_st)
                I_RECV: begin
                    if (in_flag == F_TAIL) begin
                        we_int = 1'b1;
                        in_nxt = I_IDLE;
                    end else if (in_flag == F_BODY) begin
                        we_int = 1'b1;
                        if (fcnt == FCW'(MAXLEN - 1)) begin
                            // Packet too long: close it with a forced tail.
                            wdata   = {F_TAIL, pkti[DATAW-1:0]};
                            drop_ev = 1'b1;
                            in_nxt  = I_DROP;
                        end else begin
                            fcnt_nxt = fcnt + 1'b1;
                        end
                    end
                end
                I_DROP: begin
                    if (in_flag == F_TAIL)
                        in_nxt = I_IDLE;
                end
                default: ;
            endcase
        end
    end

    assign we = we_int & rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_st <= I_IDLE;
            fcnt  <= '0;
        end else begin
            in_st <= in_nxt;
            fcnt  <= fcnt_nxt;
        end
    end

    // ---------------- FIFO ----------------
    always_ff @(posedge clk) begin
        if (we)
            mem[wptr] <= wdata;
    end

    assign front      = mem[rptr];
    assign front_flag = front[FW-1:DATAW];
    assign empty      = (cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (we)
                wptr <= wptr + 1'b1;
            if (pop)
                rptr <= rptr + 1'b1;
            case ({we, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // ---------------- output side ----------------
    always_comb begin
        pop = 1'b0;
        case (o_st)
            // Every stored packet starts with a head; anything else at the
            // front while idle is stale and is discarded.
            O_IDLE:  pop = !empty && (front_flag != F_HEAD);
            O_REQ:   pop = grant[dst] && !empty;
            // A head reached in O_SEND means the packet was closed by an
            // implicit tail; it stays queued for the next request.
            O_SEND:  pop = grant[dst] && !empty && (front_flag != F_HEAD);
            default: pop = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_st <= O_IDLE;
            req  <= '0;
            pkto <= '0;
            dst  <= '0;
        end else begin
            case (o_st)
                O_IDLE: begin
                    pkto <= '0;
                    if (!empty && front_flag == F_HEAD) begin
                        dst  <= front[DSTW-1:0];
                        req  <= NPORT'(1) << front[DSTW-1:0];
                        o_st <= O_REQ;
                    end
                end
                O_REQ: begin
                    if (pop) begin
                        pkto <= front;
                        o_st <= O_SEND;
                    end else begin
                        pkto <= '0;
                    end
                end
                O_SEND: begin
                    if (!empty && front_flag == F_HEAD) begin
                        pkto <= '0;
                        req  <= '0;
                        o_st <= O_IDLE;
                    end else if (pop) begin
                        pkto <= front;
                        if (front_flag == F_TAIL) begin
                            req  <= '0;
                            o_st <= O_IDLE;
                        end
                    end else begin
                        pkto <= '0;
                    end
                end
                default: begin
                    o_st <= O_IDLE;
                    req  <= '0;
                    pkto <= '0;
                end
            endcase
        end
    end

    // ---------------- drop statistics ----------------
`ifdef PKT_INBUF_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            drop_cnt <= '0;
        else if (drop_ev && drop_cnt != 8'hFF)
            drop_cnt <= drop_cnt + 1'b1;
    end
`else
    logic unused_drop_ev;
    assign unused_drop_ev = drop_ev;
    assign drop_cnt       = '0;
`endif

endmodule
